// File: rtl/pu_or1k_wb32_slave_ram.sv
// Wishbone B3 32-bit slave backed by an internal word RAM.
// Serves classic single cycles and registered-feedback incrementing bursts
// (linear, wrap4, wrap8, wrap16) with single-cycle first-beat latency and
// zero-wait-state burst beats. Out-of-range requests answer with one err beat.
module pu_or1k_wb32_slave_ram #(
    parameter int unsigned MEM_WORDS_LOG2 = 10,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic        wbs_we_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic [2:0]  wbs_cti_i,
    input  logic [1:0]  wbs_bte_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic        wbs_err_o,
    output logic        wbs_rty_o
);

    localparam int unsigned AW    = MEM_WORDS_LOG2;
    localparam int unsigned DEPTH = 1 << AW;

    localparam logic [2:0] CTI_INCR = 3'b010;
    localparam logic [1:0] BTE_LIN  = 2'b00;
    localparam logic [1:0] BTE_W4   = 2'b01;
    localparam logic [1:0] BTE_W8   = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        CLASSIC,
        BURST
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   cur_adr_q, cur_adr_d;
    logic            ack_q, ack_d;
    logic            err_q, err_d;
    logic [31:0]     dat_q;

    logic [31:0]     mem [DEPTH];

    logic            req_valid;
    logic            in_range;
    logic            ack_cycle;
    logic            top_wrap;
    logic [AW-1:0]   req_idx;
    logic [AW-1:0]   wrap_mask;
    logic [AW-1:0]   nxt_adr;
    logic [AW-1:0]   rd_adr;
    logic            rd_en;
    logic            mem_we;
    logic            unused_adr_bits;

    assign req_valid = wbs_cyc_i & wbs_stb_i;
    assign in_range  = (wbs_adr_i[31:AW+2] == BASE_ADDR[31:AW+2]);
    assign req_idx   = wbs_adr_i[AW+1:2];
    assign ack_cycle = ack_q & req_valid;

    // Byte offset bits carry no meaning on a 32-bit word bus.
    assign unused_adr_bits = ^wbs_adr_i[1:0];

    // Burst address increment: masked bits count, unmasked bits stay put.
    always_comb begin
        case (wbs_bte_i)
            BTE_LIN: wrap_mask = '1;
            BTE_W4:  wrap_mask = AW'(3);
            BTE_W8:  wrap_mask = AW'(7);
            default: wrap_mask = AW'(15);
        endcase
        nxt_adr  = (cur_adr_q & ~wrap_mask) | ((cur_adr_q + AW'(1)) & wrap_mask);
        top_wrap = (wbs_bte_i == BTE_LIN) && (cur_adr_q == '1);
    end

    // Next-state, handshake and RAM port control.
    always_comb begin
        state_d   = state_q;
        cur_adr_d = cur_adr_q;
        ack_d     = ack_q;
        err_d     = 1'b0;
        mem_we    = 1'b0;
        rd_en     = 1'b0;
        rd_adr    = req_idx;

        case (state_q)
            IDLE: begin
                ack_d = 1'b0;
                // err_q set means the master is still presenting the request
                // that just drew the error; it must not be answered twice.
                if (req_valid && !err_q) begin
                    if (!in_range) begin
                        err_d = 1'b1;
                    end else begin
                        cur_adr_d = req_idx;
                        ack_d     = 1'b1;
                        rd_en     = 1'b1;
                        rd_adr    = req_idx;
                        state_d   = (wbs_cti_i == CTI_INCR) ? BURST : CLASSIC;
                    end
                end
            end

            CLASSIC: begin
                if (!wbs_cyc_i) begin
                    ack_d   = 1'b0;
                    state_d = IDLE;
                end else if (ack_cycle) begin
                    mem_we  = wbs_we_i;
                    ack_d   = 1'b0;
                    state_d = IDLE;
                end
            end

            BURST: begin
                if (!wbs_cyc_i) begin
                    ack_d   = 1'b0;
                    state_d = IDLE;
                end else if (ack_cycle) begin
                    if (req_idx != cur_adr_q) begin
                        // Master restarted elsewhere: drop out and let IDLE
                        // take the new address as a fresh request.
                        ack_d   = 1'b0;
                        state_d = IDLE;
                    end else begin
                        mem_we = wbs_we_i;
                        if (wbs_cti_i == CTI_INCR) begin
                            if (top_wrap) begin
                                ack_d   = 1'b0;
                                err_d   = 1'b1;
                                state_d = IDLE;
                            end else begin
                                cur_adr_d = nxt_adr;
                                rd_en     = 1'b1;
                                rd_adr    = nxt_adr;
                            end
                        end else begin
                            ack_d   = 1'b0;
                            state_d = IDLE;
                        end
                    end
                end
            end

            default: begin
                ack_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // Control and read-data registers; the RAM array itself is never reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cur_adr_q <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            dat_q     <= '0;
        end else begin
            state_q   <= state_d;
            cur_adr_q <= cur_adr_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            if (rd_en) begin
                dat_q <= mem[rd_adr];
            end
        end
    end

    // RAM write port with per-byte lane enables; a beat cut off by reset is not written.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            for (int unsigned n = 0; n < 4; n++) begin
                if (wbs_sel_i[n]) begin
                    mem[cur_adr_q][8*n +: 8] <= wbs_dat_i[8*n +: 8];
                end
            end
        end
    end

    assign wbs_dat_o = dat_q;
    assign wbs_ack_o = ack_q & wbs_cyc_i & wbs_stb_i;
    assign wbs_err_o = err_q & wbs_cyc_i & wbs_stb_i;
    assign wbs_rty_o = 1'b0;

endmodule

// File: tb/tb_pu_or1k_wb32_slave_ram.sv
// Bench for pu_or1k_wb32_slave_ram: a Wishbone master driving directed and
// random transactions against a word-array model of the RAM. Per-cycle
// expectations come from the bus timing rules; one negedge process compares.
module tb_pu_or1k_wb32_slave_ram;

    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] adr = '0;
    logic [31:0] dat_i = '0;
    logic [3:0]  sel = '0;
    logic        we = 1'b0;
    logic        stb = 1'b0;
    logic        cyc = 1'b0;
    logic [2:0]  cti = '0;
    logic [1:0]  bte = '0;
    logic [31:0] dat_o;
    logic        ack_o;
    logic        err_o;
    logic        rty_o;

    pu_or1k_wb32_slave_ram #(
        .MEM_WORDS_LOG2(10),
        .BASE_ADDR     (BASE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wbs_adr_i(adr),
        .wbs_dat_i(dat_i),
        .wbs_sel_i(sel),
        .wbs_we_i (we),
        .wbs_stb_i(stb),
        .wbs_cyc_i(cyc),
        .wbs_cti_i(cti),
        .wbs_bte_i(bte),
        .wbs_dat_o(dat_o),
        .wbs_ack_o(ack_o),
        .wbs_err_o(err_o),
        .wbs_rty_o(rty_o)
    );

    always #5 clk = ~clk;

    // Reference state: RAM image plus a flag for words whose value is known.
    logic [31:0] mm [DEPTH];
    bit          mv [DEPTH];
    logic [31:0] bdat [DEPTH];
    logic [31:0] cap [$];

    // Expectations for the current cycle.
    bit          chk_en = 1'b0;
    logic        exp_ack = 1'b0;
    logic        exp_err = 1'b0;
    bit          exp_dat_chk = 1'b0;
    logic [31:0] exp_dat = '0;

    int nchecks = 0;
    int nerrors = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] capv(input int i);
        if (i < cap.size()) return cap[i];
        return 32'hxxxx_xxxx;
    endfunction

    function automatic void model_write(input int unsigned idx, input logic [31:0] d, input logic [3:0] s);
        for (int n = 0; n < 4; n++)
            if (s[n]) mm[idx][8*n +: 8] = d[8*n +: 8];
        if (s == 4'hF) mv[idx] = 1'b1;
    endfunction

    // Word index of beat k of a burst; linear bursts may run past the top (error beat).
    function automatic int unsigned beat_idx(input int unsigned s, input logic [1:0] b, input int unsigned k);
        int unsigned blk;
        if (b == 2'b00) return s + k;
        blk = 2 << b;
        return (s / blk) * blk + ((s % blk) + k) % blk;
    endfunction

    // Single compare process: checks the bus outputs every cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("ack", {31'b0, ack_o}, {31'b0, exp_ack});
            chk("err", {31'b0, err_o}, {31'b0, exp_err});
            chk("rty", {31'b0, rty_o}, 32'd0);
            if (exp_dat_chk) chk("dat", dat_o, exp_dat);
            if (ack_o === 1'b1 && !we) cap.push_back(dat_o);
        end
    end

    task automatic cycle_go();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000;
        exp_ack = 1'b0; exp_err = 1'b0; exp_dat_chk = 1'b0;
        repeat (n) cycle_go();
    endtask

    task automatic classic(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s);
        int unsigned idx;
        bit inr;
        idx = int'(a[11:2]);
        inr = (a[31:12] == BASE[31:12]);
        cap.delete();
        adr = a; we = w; dat_i = d; sel = s; cti = 3'b000; bte = 2'b00; cyc = 1'b1; stb = 1'b1;
        exp_ack = 1'b0; exp_err = 1'b0; exp_dat_chk = 1'b0;
        cycle_go();
        exp_ack = inr; exp_err = !inr;
        exp_dat_chk = inr && !w && mv[idx];
        exp_dat = mm[idx];
        cycle_go();
        if (inr && w) model_write(idx, d, s);
        idle(1);
    endtask

    task automatic burst(input int unsigned start, input logic [1:0] b, input int unsigned n,
                         input logic w, input bit waits);
        int unsigned ak;
        cap.delete();
        ak = beat_idx(start, b, 0);
        adr = BASE + 32'(ak * 4); we = w; sel = 4'hF; bte = b;
        cti = (n == 1) ? 3'b111 : 3'b010; cyc = 1'b1; stb = 1'b1; dat_i = bdat[0];
        exp_ack = 1'b0; exp_err = 1'b0; exp_dat_chk = 1'b0;
        cycle_go();
        for (int unsigned k = 0; k < n; k++) begin
            ak = beat_idx(start, b, k);
            if (waits && ak < DEPTH && $urandom_range(0, 3) == 0) begin
                stb = 1'b0; exp_ack = 1'b0; exp_err = 1'b0; exp_dat_chk = 1'b0;
                cycle_go();
                stb = 1'b1;
            end
            cti = (k == n - 1) ? 3'b111 : 3'b010;
            if (ak >= DEPTH) begin
                adr = BASE + 32'((ak % DEPTH) * 4);
                exp_ack = 1'b0; exp_err = 1'b1; exp_dat_chk = 1'b0;
                cycle_go();
                break;
            end
            adr = BASE + 32'(ak * 4); dat_i = bdat[k];
            exp_ack = 1'b1; exp_err = 1'b0;
            exp_dat_chk = !w && mv[ak];
            exp_dat = mm[ak];
            cycle_go();
            if (w) model_write(ak, bdat[k], 4'hF);
        end
        idle(1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) begin mm[i] = '0; mv[i] = 1'b0; bdat[i] = '0; end

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;
        exp_ack = 1'b0; exp_err = 1'b0; exp_dat_chk = 1'b1; exp_dat = 32'h0;
        cycle_go();
        idle(1);

        // Classic write then read
        classic(BASE + 32'h10, 1'b1, 32'hDEAD_BEEF, 4'hF);
        classic(BASE + 32'h10, 1'b0, 32'h0, 4'hF);
        chk("classic_rd", capv(0), 32'hDEAD_BEEF);

        // Byte lanes
        classic(BASE + 32'h20, 1'b1, 32'h1122_3344, 4'hF);
        classic(BASE + 32'h20, 1'b1, 32'hAABB_CCDD, 4'b0101);
        classic(BASE + 32'h20, 1'b0, 32'h0, 4'hF);
        chk("byte_lanes", capv(0), 32'h11BB_33DD);

        // Wrap4 read burst from word 6
        for (int i = 0; i < 8; i++) bdat[i] = 32'(i);
        burst(0, 2'b00, 8, 1'b1, 1'b0);
        burst(6, 2'b01, 4, 1'b0, 1'b0);
        chk("wrap4_n", 32'(cap.size()), 32'd4);
        chk("wrap4_b0", capv(0), 32'd6);
        chk("wrap4_b1", capv(1), 32'd7);
        chk("wrap4_b2", capv(2), 32'd4);
        chk("wrap4_b3", capv(3), 32'd5);

        // Linear 8-beat write burst, then read each word back
        for (int i = 0; i < 8; i++) bdat[i] = 32'h100 + 32'(i);
        burst(0, 2'b00, 8, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            classic(BASE + 32'(i * 4), 1'b0, 32'h0, 4'hF);
            chk("lin_rd", capv(0), 32'h100 + 32'(i));
        end

        // Out of range: err once, no ack, aliasing word 0 untouched
        classic(BASE + 32'h1000, 1'b1, 32'hBAD0_BAD0, 4'hF);
        classic(BASE + 32'h0, 1'b0, 32'h0, 4'hF);
        chk("oor_untouched", capv(0), 32'h100);

        // Linear burst from top word: first beat acks, second errs
        bdat[0] = 32'hCAFE_0001; bdat[1] = 32'hCAFE_0002;
        burst(1023, 2'b00, 2, 1'b1, 1'b0);
        classic(BASE + 32'(1023 * 4), 1'b0, 32'h0, 4'hF);
        chk("top_beat0", capv(0), 32'hCAFE_0001);
        classic(BASE + 32'h0, 1'b0, 32'h0, 4'hF);
        chk("top_no_wrap", capv(0), 32'h100);

        // Reset after beat 2 of an 8-beat write burst
        for (int i = 0; i < 8; i++) bdat[i] = 32'h7000 + 32'(i);
        adr = BASE + 32'(64 * 4); we = 1'b1; sel = 4'hF; bte = 2'b00; cti = 3'b010;
        cyc = 1'b1; stb = 1'b1; dat_i = bdat[0];
        exp_ack = 1'b0; exp_err = 1'b0; exp_dat_chk = 1'b0;
        cycle_go();
        for (int k = 0; k < 2; k++) begin
            adr = BASE + 32'((64 + k) * 4); dat_i = bdat[k];
            exp_ack = 1'b1;
            cycle_go();
            model_write(64 + k, bdat[k], 4'hF);
        end
        adr = BASE + 32'(66 * 4); dat_i = bdat[2];
        mv[66] = 1'b0;
        chk_en = 1'b0; rst = 1'b1;
        cycle_go();
        rst = 1'b0; chk_en = 1'b1;
        exp_ack = 1'b0; exp_err = 1'b0; exp_dat_chk = 1'b1; exp_dat = 32'h0;
        cycle_go();
        idle(2);
        classic(BASE + 32'(64 * 4), 1'b0, 32'h0, 4'hF);
        chk("rst_keep0", capv(0), 32'h7000);
        classic(BASE + 32'(65 * 4), 1'b0, 32'h0, 4'hF);
        chk("rst_keep1", capv(0), 32'h7001);

        // Fill the whole RAM so every later read has a known value
        for (int i = 0; i < int'(DEPTH); i++) bdat[i] = $urandom;
        burst(0, 2'b00, DEPTH, 1'b1, 1'b0);

        // Random traffic
        for (int t = 0; t < 300; t++) begin
            int unsigned kind;
            int unsigned idx;
            int unsigned n;
            logic [1:0]  b;
            logic        w;
            kind = $urandom_range(0, 9);
            w = 1'($urandom_range(0, 1));
            if (kind < 3) begin
                idx = $urandom_range(0, DEPTH - 1);
                classic(BASE + 32'(idx * 4) + 32'($urandom_range(0, 3)), w, $urandom,
                        4'($urandom_range(1, 15)));
            end else if (kind == 3) begin
                classic($urandom | 32'h0000_1000, w, $urandom, 4'hF);
            end else begin
                b = 2'($urandom_range(0, 3));
                n = $urandom_range(1, 16);
                idx = ($urandom_range(0, 3) == 0) ? $urandom_range(DEPTH - 16, DEPTH - 1)
                                                  : $urandom_range(0, DEPTH - 1);
                for (int i = 0; i < 16; i++) bdat[i] = $urandom;
                burst(idx, b, n, w, 1'b1);
            end
        end

        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
